cache_fsm: RTL and testbench
============================

CACHE_FSM -- requirements
Module: cache_fsm

Interface
REQ-001 Parameter: none; line length, tag and set sizing belong to the datapath and are not visible to this block.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cif  modport cache_internal_if.controller  --  drives all datapath strobes; samples counter_done, valid_block_match, valid_dirty_bit.
REQ-005 cpu_req_valid  input  1  CPU request present.
REQ-006 cpu_req_op  input  1  0 = read, 1 = write; sampled only on acceptance.
REQ-007 cpu_req_ready  output  1  high only in IDLE; acceptance = valid & ready.
REQ-008 cpu_resp_valid  output  1  one-cycle pulse: request completed.
REQ-009 hmem_req_valid  output  1  word transfer request to higher memory.
REQ-010 hmem_req_op  output  1  0 = read (fill), 1 = write (writeback).
REQ-011 hmem_ack  input  1  one word transferred this cycle.

Function
REQ-012 States: IDLE, COMPARE, WRITEBACK, FILL, INSTALL; encoding in the shared package.
REQ-013 IDLE: on acceptance, latch cpu_req_op into op_q, clear replay_q, go to COMPARE; otherwise stay.
REQ-014 COMPARE, valid_block_match=1 (hit): assert process_lru_counters, cpu_resp_valid; if op_q=1 also assert perform_write and set_selected_dirty_bit; go to IDLE.
REQ-015 COMPARE, miss, valid_dirty_bit=1: assert miss_recovery_mode, set_hmem_block_address, use_victim_tag_for_hmem_block_address, reset_counter; go to WRITEBACK.
REQ-016 COMPARE, miss, valid_dirty_bit=0: assert miss_recovery_mode, set_hmem_block_address, clear_selected_valid_bit, reset_counter; go to FILL.
REQ-017 WRITEBACK: hmem_req_valid=1, hmem_req_op=1; decrement_counter=hmem_ack; on hmem_ack & counter_done assert clear_selected_dirty_bit, clear_selected_valid_bit, set_hmem_block_address (victim select 0), reset_counter, go to FILL.
REQ-018 FILL: hmem_req_valid=1, hmem_req_op=0; decrement_counter=hmem_ack; on hmem_ack & counter_done go to INSTALL.
REQ-019 INSTALL: finish_new_line_install=1 for exactly one cycle; set replay_q; go to COMPARE (replay, which must hit).
REQ-020 miss_recovery_mode=1 throughout WRITEBACK, FILL, INSTALL and on COMPARE miss cycles.
REQ-021 Hit latency: cpu_resp_valid exactly 1 cycle after acceptance; miss latency = 1 + writeback words + fill words + 2 cycles, plus hmem stall cycles.
REQ-022 hmem_ack outside WRITEBACK/FILL ignored; cpu_req_valid while busy ignored (ready=0), request not lost on CPU side.
REQ-023 Replay COMPARE with valid_block_match=0 is a datapath fault: block re-enters miss path per REQ-015/016 (no lockup).
REQ-024 All strobes not listed for a state/condition are 0.

Reset
REQ-025 rst_n low, at any time including mid-WRITEBACK/FILL: state=IDLE, op_q=0, replay_q=0, all outputs 0 except cpu_req_ready=1 after release; partial line abandoned.

Configuration
REQ-026 Macro CACHE_PERF_COUNTERS_EN defined: in COMPARE with replay_q=0 assert count_read (op_q=0) or count_write (op_q=1) plus count_hit or count_miss; replay COMPARE asserts none.
REQ-027 Macro undefined: count_hit, count_miss, count_read, count_write tied 0; all other behaviour identical.

Structure
REQ-028 Shared package cache_pkg: state enum cache_fsm_state_e, op typedef cache_op_e (READ=0, WRITE=1).
REQ-029 Single flat module; no sub-module; one state register, combinational output decode.

Verification
REQ-030 Read hit: accept op=0, match=1 -> resp_valid at cycle+1, process_lru_counters=1, perform_write=0, back to IDLE.
REQ-031 Write hit: op=1, match=1 -> perform_write and set_selected_dirty_bit high same cycle as resp_valid.
REQ-032 Clean miss, 4-word line, ack every cycle: FILL 4 cycles, INSTALL 1, replay hit; resp_valid 7 cycles after acceptance; no hmem write.
REQ-033 Dirty miss, 4-word line, ack every other cycle: 4 writes with victim tag, dirty cleared on last ack, then 4 reads; decrement_counter count equals ack count.
REQ-034 rst_n pulsed low mid-FILL (word 2): hmem_req_valid drops asynchronously, next request handled from IDLE normally.
REQ-035 With CACHE_PERF_COUNTERS_EN, dirty-miss read: count_read=1 and count_miss=1 once each, count_hit=0 on replay; without macro all four stay 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache controller: FSM state encoding and CPU request opcode.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_INSTALL   = 3'd4
    } cache_fsm_state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } cache_op_e;

endpackage

// File: rtl/cache_internal_if.sv
// Strobe/status bundle between the cache controller FSM and its datapath.
interface cache_internal_if;

    logic counter_done;
    logic valid_block_match;
    logic valid_dirty_bit;

    logic process_lru_counters;
    logic perform_write;
    logic set_selected_dirty_bit;
    logic clear_selected_dirty_bit;
    logic clear_selected_valid_bit;
    logic miss_recovery_mode;
    logic set_hmem_block_address;
    logic use_victim_tag_for_hmem_block_address;
    logic reset_counter;
    logic decrement_counter;
    logic finish_new_line_install;
    logic count_hit;
    logic count_miss;
    logic count_read;
    logic count_write;

    modport controller (
        input  counter_done, valid_block_match, valid_dirty_bit,
        output process_lru_counters, perform_write, set_selected_dirty_bit,
               clear_selected_dirty_bit, clear_selected_valid_bit, miss_recovery_mode,
               set_hmem_block_address, use_victim_tag_for_hmem_block_address,
               reset_counter, decrement_counter, finish_new_line_install,
               count_hit, count_miss, count_read, count_write
    );

    modport datapath (
        output counter_done, valid_block_match, valid_dirty_bit,
        input  process_lru_counters, perform_write, set_selected_dirty_bit,
               clear_selected_dirty_bit, clear_selected_valid_bit, miss_recovery_mode,
               set_hmem_block_address, use_victim_tag_for_hmem_block_address,
               reset_counter, decrement_counter, finish_new_line_install,
               count_hit, count_miss, count_read, count_write
    );

endinterface

// File: rtl/cache_fsm.sv
// Cache controller FSM: hit service, dirty-victim writeback, line fill, install and replay.
// Optional macro CACHE_PERF_COUNTERS_EN enables hit/miss/read/write count strobes.
module cache_fsm
    import cache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    cache_internal_if.controller        cif,
    input  logic                        cpu_req_valid,
    input  logic                        cpu_req_op,
    output logic                        cpu_req_ready,
    output logic                        cpu_resp_valid,
    output logic                        hmem_req_valid,
    output logic                        hmem_req_op,
    input  logic                        hmem_ack
);

    cache_fsm_state_e r_state;
    cache_fsm_state_e w_state_nxt;
    cache_op_e        r_op_q;
    logic             w_accept;

    assign w_accept = cpu_req_valid && (r_state == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the async reset clears them mid-cycle too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op_q  <= READ;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op_q <= cache_op_e'(cpu_req_op);
            end
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    // Marks the post-install COMPARE so it is not counted as a second access.
    logic r_replay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_replay_q <= 1'b0;
        end else if (w_accept) begin
            r_replay_q <= 1'b0;
        end else if (r_state == ST_INSTALL) begin
            r_replay_q <= 1'b1;
        end
    end
`endif

    // NOTE: every output and the next state get a default before the case,
    // so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt                               = r_state;
        cpu_req_ready                             = 1'b0;
        cpu_resp_valid                            = 1'b0;
        hmem_req_valid                            = 1'b0;
        hmem_req_op                               = 1'b0;
        cif.process_lru_counters                  = 1'b0;
        cif.perform_write                         = 1'b0;
        cif.set_selected_dirty_bit                = 1'b0;
        cif.clear_selected_dirty_bit              = 1'b0;
        cif.clear_selected_valid_bit              = 1'b0;
        cif.miss_recovery_mode                    = 1'b0;
        cif.set_hmem_block_address                = 1'b0;
        cif.use_victim_tag_for_hmem_block_address = 1'b0;
        cif.reset_counter                         = 1'b0;
        cif.decrement_counter                     = 1'b0;
        cif.finish_new_line_install               = 1'b0;
        cif.count_hit                             = 1'b0;
        cif.count_miss                            = 1'b0;
        cif.count_read                            = 1'b0;
        cif.count_write                           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cpu_req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
`ifdef CACHE_PERF_COUNTERS_EN
                if (!r_replay_q) begin
                    cif.count_read  = (r_op_q == READ);
                    cif.count_write = (r_op_q == WRITE);
                    cif.count_hit   = cif.valid_block_match;
                    cif.count_miss  = !cif.valid_block_match;
                end
`endif
                if (cif.valid_block_match) begin
                    cif.process_lru_counters = 1'b1;
                    cpu_resp_valid           = 1'b1;
                    if (r_op_q == WRITE) begin
                        cif.perform_write          = 1'b1;
                        cif.set_selected_dirty_bit = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    // A miss on replay is a datapath fault; re-entering recovery avoids lockup.
                    cif.miss_recovery_mode     = 1'b1;
                    cif.set_hmem_block_address = 1'b1;
                    cif.reset_counter          = 1'b1;
                    if (cif.valid_dirty_bit) begin
                        cif.use_victim_tag_for_hmem_block_address = 1'b1;
                        w_state_nxt = ST_WRITEBACK;
                    end else begin
                        cif.clear_selected_valid_bit = 1'b1;
                        w_state_nxt = ST_FILL;
                    end
                end
            end

            ST_WRITEBACK: begin
                cif.miss_recovery_mode = 1'b1;
                hmem_req_valid         = 1'b1;
                hmem_req_op            = 1'b1;
                cif.decrement_counter  = hmem_ack;
                if (hmem_ack && cif.counter_done) begin
                    cif.clear_selected_dirty_bit = 1'b1;
                    cif.clear_selected_valid_bit = 1'b1;
                    cif.set_hmem_block_address   = 1'b1;
                    cif.reset_counter            = 1'b1;
                    w_state_nxt                  = ST_FILL;
                end
            end

            ST_FILL: begin
                cif.miss_recovery_mode = 1'b1;
                hmem_req_valid         = 1'b1;
                cif.decrement_counter  = hmem_ack;
                if (hmem_ack && cif.counter_done) begin
                    w_state_nxt = ST_INSTALL;
                end
            end

            ST_INSTALL: begin
                cif.miss_recovery_mode      = 1'b1;
                cif.finish_new_line_install = 1'b1;
                w_state_nxt                 = ST_COMPARE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fsm.sv
// Scoreboard bench for cache_fsm: directed hit/miss/writeback/reset vectors, 4-word line model.
module tb_cache_fsm;

    typedef struct {
        int lat;  int wr;  int rd;  int dec;  int victim; int clrd;
        int pw;   int sd;  int cr;  int cw;   int ch;     int cm;
    } exp_t;

`ifdef CACHE_PERF_COUNTERS_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_req_valid = 1'b0;
    logic cpu_req_op = 1'b0;
    logic cpu_req_ready, cpu_resp_valid, hmem_req_valid, hmem_req_op;
    logic hmem_ack = 1'b0;

    cache_internal_if cif_i ();

    cache_fsm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cif            (cif_i),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_op     (cpu_req_op),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .hmem_req_valid (hmem_req_valid),
        .hmem_req_op    (hmem_req_op),
        .hmem_ack       (hmem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Datapath model: one selected line plus the 4-word transfer counter.
    logic       m_valid = 1'b0, m_dirty = 1'b0, m_match = 1'b0;
    logic [1:0] m_cnt = 2'd0;
    logic       do_preset = 1'b0;
    logic [2:0] preset = 3'b000;  // {valid, dirty, match}

    assign cif_i.counter_done      = (m_cnt == 2'd0);
    assign cif_i.valid_block_match = m_valid & m_match;
    assign cif_i.valid_dirty_bit   = m_valid & m_dirty;

    always @(posedge clk) begin
        if (do_preset) begin
            {m_valid, m_dirty, m_match} <= preset;
        end else begin
            if (cif_i.reset_counter)          m_cnt <= 2'd3;
            else if (cif_i.decrement_counter) m_cnt <= m_cnt - 2'd1;
            if (cif_i.clear_selected_valid_bit) m_valid <= 1'b0;
            if (cif_i.clear_selected_dirty_bit) m_dirty <= 1'b0;
            if (cif_i.set_selected_dirty_bit)   m_dirty <= 1'b1;
            if (cif_i.finish_new_line_install) begin
                m_valid <= 1'b1;
                m_match <= 1'b1;
                m_dirty <= 1'b0;
            end
        end
    end

    // Higher-memory responder: ack every cycle (mode 0) or every other cycle (mode 1).
    int   ack_mode = 0;
    logic ack_phase = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (hmem_req_valid) begin
            hmem_ack  = (ack_mode == 0) ? 1'b1 : ack_phase;
            ack_phase = ~ack_phase;
        end else begin
            hmem_ack  = 1'b0;
            ack_phase = 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];

    // Monitor: accumulates per-transaction activity, compares on each response.
    bit busy = 1'b0;
    int acc_cyc, a_wr, a_rd, a_dec, a_vic, a_clrd, a_cr, a_cw, a_ch, a_cm;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                if (hmem_req_valid && hmem_ack) begin
                    if (hmem_req_op) a_wr++; else a_rd++;
                end
                a_dec  += int'(cif_i.decrement_counter);
                a_vic  += int'(cif_i.use_victim_tag_for_hmem_block_address);
                a_clrd += int'(cif_i.clear_selected_dirty_bit);
                a_cr   += int'(cif_i.count_read);
                a_cw   += int'(cif_i.count_write);
                a_ch   += int'(cif_i.count_hit);
                a_cm   += int'(cif_i.count_miss);
            end
            if (cpu_resp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency",      cyc - acc_cyc, e.lat);
                    check("hmem_writes",  a_wr, e.wr);
                    check("hmem_reads",   a_rd, e.rd);
                    check("decrements",   a_dec, e.dec);
                    check("victim_tag",   a_vic, e.victim);
                    check("clear_dirty",  a_clrd, e.clrd);
                    check("perform_write", int'(cif_i.perform_write), e.pw);
                    check("set_dirty",    int'(cif_i.set_selected_dirty_bit), e.sd);
                    check("lru_on_resp",  int'(cif_i.process_lru_counters), 1);
                    check("ready_busy",   int'(cpu_req_ready), 0);
                    check("count_read",   a_cr, e.cr);
                    check("count_write",  a_cw, e.cw);
                    check("count_hit",    a_ch, e.ch);
                    check("count_miss",   a_cm, e.cm);
                end
                busy = 1'b0;
            end
            if (cpu_req_valid && cpu_req_ready) begin
                busy = 1'b1;
                acc_cyc = cyc;
                {a_wr, a_rd, a_dec, a_vic, a_clrd} = '0;
                {a_cr, a_cw, a_ch, a_cm} = '0;
            end
        end
    end

    function automatic exp_t mk(int lat, int wr, int rd, int victim, int clrd,
                                int pw, int sd, int op, int hit);
        exp_t e;
        e.lat = lat; e.wr = wr; e.rd = rd; e.dec = wr + rd;
        e.victim = victim; e.clrd = clrd; e.pw = pw; e.sd = sd;
        e.cr = PF * (1 - op); e.cw = PF * op;
        e.ch = PF * hit;      e.cm = PF * (1 - hit);
        return e;
    endfunction

    task automatic setup(input logic [2:0] line, input int mode);
        @(posedge clk); #1;
        preset = line; do_preset = 1'b1; ack_mode = mode;
        @(posedge clk); #1;
        do_preset = 1'b0;
    endtask

    task automatic issue(input logic op);
        bit taken = 1'b0;
        cpu_req_valid = 1'b1;
        cpu_req_op    = op;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clk);
            taken = cpu_req_ready;
        end
        if (!taken) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
    endtask

    task automatic run_req(input logic op, input logic [2:0] line, input int mode,
                           input exp_t e);
        setup(line, mode);
        sb.push_back(e);
        issue(op);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("resp_timeout", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        #12;
        check("rst_hmem_valid", int'(hmem_req_valid), 0);
        check("rst_resp_valid", int'(cpu_resp_valid), 0);
        check("rst_miss_mode",  int'(cif_i.miss_recovery_mode), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", int'(cpu_req_ready), 1);

        // read hit, write hit
        run_req(1'b0, 3'b101, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
        run_req(1'b1, 3'b101, 0, mk(1, 0, 0, 0, 0, 1, 1, 1, 1));
        // clean misses, ack every cycle: 1 + 4 + 2 = 7
        run_req(1'b0, 3'b100, 0, mk(7, 0, 4, 0, 0, 0, 0, 0, 0));
        run_req(1'b1, 3'b100, 0, mk(7, 0, 4, 0, 0, 1, 1, 1, 0));
        // dirty miss, ack every other cycle: 1 + 8 + 8 + 2 = 19
        run_req(1'b0, 3'b110, 1, mk(19, 4, 4, 1, 1, 0, 0, 0, 0));

        // reset pulsed during fill
        setup(3'b100, 0);
        issue(1'b0);
        repeat (3) @(posedge clk);
        #3;
        check("fill_in_progress", int'(hmem_req_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_hmem_drop", int'(hmem_req_valid), 0);
        check("async_miss_mode", int'(cif_i.miss_recovery_mode), 0);
        check("async_resp",      int'(cpu_resp_valid), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", int'(cpu_req_ready), 1);
        check("post_rst_hmem",  int'(hmem_req_valid), 0);
        run_req(1'b0, 3'b101, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
